// File: rtl/rd_wait_slave_if.sv
// Read handshake between the go/ws/rd/ds controller and the rd_wait_slave responder.
interface rd_wait_slave_if #(
  parameter int DATA_W = 8
);
  logic              rd;
  logic              ds;
  logic              ws;
  logic [DATA_W-1:0] data;
  logic              data_valid;

  modport master (output rd, output ds, input ws, input data, input data_valid);
  modport slave  (input rd, input ds, output ws, output data, output data_valid);
endinterface

// File: rtl/rd_wait_slave.sv
// Wait-state read responder: programmable ws stretch, then streams mem[addr] with auto-increment.
// Optional macro RD_WAIT_SLAVE_WRITE_EN adds a write port into the register array.
module rd_wait_slave #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  rd_wait_slave_if.slave    bus,
  input  logic [CNT_W-1:0]  wait_cfg,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] addr
`ifdef RD_WAIT_SLAVE_WRITE_EN
  ,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] start_addr;

  // A load in the same cycle as rd targets the freshly loaded address.
  always_comb begin
    start_addr = addr;
    if (addr_load) start_addr = addr_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i * 17);
    end
`ifdef RD_WAIT_SLAVE_WRITE_EN
    else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      addr           <= '0;
      bus.ws         <= 1'b0;
      bus.data       <= '0;
      bus.data_valid <= 1'b0;
      busy           <= 1'b0;
      err            <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          addr <= start_addr;
          if (bus.rd) begin
            busy <= 1'b1;
            if (wait_cfg != '0) begin
              state  <= S_WAIT;
              cnt    <= wait_cfg;
              bus.ws <= 1'b1;
            end else begin
              state          <= S_READY;
              bus.data       <= mem[start_addr];
              bus.data_valid <= 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (!bus.rd && !bus.ds) begin
            state  <= S_IDLE;
            cnt    <= '0;
            bus.ws <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b1;
          end else if (cnt > CNT_W'(1)) begin
            cnt <= cnt - 1'b1;
          end else if (bus.rd) begin
            state          <= S_READY;
            cnt            <= '0;
            bus.ws         <= 1'b0;
            bus.data       <= mem[addr];
            bus.data_valid <= 1'b1;
          end
        end

        S_READY: begin
          if (bus.ds) begin
            state          <= S_IDLE;
            addr           <= addr + 1'b1;
            bus.data       <= '0;
            bus.data_valid <= 1'b0;
            busy           <= 1'b0;
          end else if (!bus.rd) begin
            state          <= S_IDLE;
            bus.data       <= '0;
            bus.data_valid <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b1;
          end else begin
            // Re-sample each cycle so a write to the presented word shows up.
            bus.data <= mem[addr];
          end
        end

        default: begin
          state          <= S_IDLE;
          bus.ws         <= 1'b0;
          bus.data       <= '0;
          bus.data_valid <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule
